// File: rtl/lsu_pkg.sv
// Shared types and helpers for the load/store data path: access sizes, the
// request FSM states, and the load extract/extend rule.
package lsu_pkg;

    localparam int WORD_W = 64;

    typedef enum logic [1:0] {
        SZ_B = 2'd0,
        SZ_H = 2'd1,
        SZ_W = 2'd2,
        SZ_D = 2'd3
    } lsu_size_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } lsu_state_e;

    function automatic logic [3:0] size_bytes(input lsu_size_e size);
        return 4'd1 << size;
    endfunction

    function automatic logic misaligned(input lsu_size_e size, input logic [2:0] offset);
        case (size)
            SZ_B:    return 1'b0;
            SZ_H:    return offset[0];
            SZ_W:    return |offset[1:0];
            default: return |offset;
        endcase
    endfunction

    function automatic logic [WORD_W-1:0] load_extend(input logic [WORD_W-1:0] word,
                                                      input logic [2:0] offset,
                                                      input lsu_size_e size,
                                                      input logic is_unsigned);
        logic [WORD_W-1:0] s;
        s = word >> {offset, 3'b000};
        case (size)
            SZ_B:    return is_unsigned ? {56'd0, s[7:0]}  : {{56{s[7]}}, s[7:0]};
            SZ_H:    return is_unsigned ? {48'd0, s[15:0]} : {{48{s[15]}}, s[15:0]};
            SZ_W:    return is_unsigned ? {32'd0, s[31:0]} : {{32{s[31]}}, s[31:0]};
            default: return s;
        endcase
    endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// Combinational lane logic: merges store bytes into a word and extracts/extends
// load data from a word. Shared with the cache data path.
module lsu_lane_align
    import lsu_pkg::*;
(
    input  logic [WORD_W-1:0] st_word,
    input  logic [WORD_W-1:0] st_data,
    input  logic [2:0]        st_offset,
    input  lsu_size_e         st_size,
    output logic [WORD_W-1:0] st_merged,
    input  logic [WORD_W-1:0] ld_word,
    input  logic [2:0]        ld_offset,
    input  lsu_size_e         ld_size,
    input  logic              ld_unsigned,
    output logic [WORD_W-1:0] ld_data
);

    logic [7:0]        st_be;
    logic [WORD_W-1:0] st_shifted;

    always_comb begin
        // Store data comes from the low bytes of st_data, moved up to the lane.
        st_be      = 8'(((16'd1 << size_bytes(st_size)) - 16'd1) << st_offset);
        st_shifted = st_data << {st_offset, 3'b000};
        st_merged  = st_word;
        for (int i = 0; i < 8; i++) begin
            if (st_be[i]) st_merged[8*i +: 8] = st_shifted[8*i +: 8];
        end
        ld_data = load_extend(ld_word, ld_offset, ld_size, ld_unsigned);
    end

endmodule

// File: rtl/lsu_data_memory.sv
// Load/store data memory with a valid/ready request port, registered one-pulse
// response, configurable read latency and misalign/range error detection.
module lsu_data_memory
    import lsu_pkg::*;
#(
    parameter int XLEN    = 64,
    parameter int DEPTH   = 1024,
    parameter int ADDR_W  = 64,
    parameter int LATENCY = 2
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [1:0]        req_size,
    input  logic              req_unsigned,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [XLEN-1:0]   req_wdata,
    output logic              resp_valid,
    output logic [XLEN-1:0]   resp_rdata,
    output logic              resp_error,
    output logic              busy,
    output lsu_state_e        fsm_state
);

    localparam int IDX      = $clog2(DEPTH);
    localparam int CNT_W    = (LATENCY > 2) ? $clog2(LATENCY - 1) : 1;
    localparam int CNT_INIT = (LATENCY > 2) ? LATENCY - 2 : 0;

    logic [XLEN-1:0] mem [DEPTH];

    lsu_state_e      state, state_d;
    logic [CNT_W-1:0] cnt, cnt_d;
    logic            resp_valid_d, resp_error_d;
    logic [XLEN-1:0] resp_rdata_d;

    logic [IDX-1:0]  req_idx, ld_idx_q, ld_idx;
    logic [2:0]      req_off, ld_off_q, ld_off;
    lsu_size_e       req_sz, ld_sz_q, ld_sz;
    logic            ld_uns_q, ld_uns;
    logic            req_err, accept, mem_we;
    logic [XLEN-1:0] st_merged, ld_data;

    assign req_sz  = lsu_size_e'(req_size);
    assign req_off = req_addr[2:0];
    assign req_idx = req_addr[IDX+2:3];
    assign req_err = ((req_addr >> (IDX + 3)) != '0) || misaligned(req_sz, req_off);

    assign req_ready = (state != WAIT);
    assign busy      = (state != IDLE);
    assign fsm_state = state;
    assign accept    = req_valid && req_ready;

    // A WAIT load reads with its captured fields; a LATENCY=1 load reads with the live request.
    assign ld_idx = (state == WAIT) ? ld_idx_q : req_idx;
    assign ld_off = (state == WAIT) ? ld_off_q : req_off;
    assign ld_sz  = (state == WAIT) ? ld_sz_q  : req_sz;
    assign ld_uns = (state == WAIT) ? ld_uns_q : req_unsigned;

    lsu_lane_align u_lane_align (
        .st_word     (mem[req_idx]),
        .st_data     (req_wdata),
        .st_offset   (req_off),
        .st_size     (req_sz),
        .st_merged   (st_merged),
        .ld_word     (mem[ld_idx]),
        .ld_offset   (ld_off),
        .ld_size     (ld_sz),
        .ld_unsigned (ld_uns),
        .ld_data     (ld_data)
    );

    always_comb begin
        state_d      = state;
        cnt_d        = cnt;
        resp_valid_d = 1'b0;
        resp_error_d = 1'b0;
        resp_rdata_d = '0;
        mem_we       = 1'b0;
        case (state)
            WAIT: begin
                if (cnt == '0) begin
                    state_d      = RESP;
                    resp_valid_d = 1'b1;
                    resp_rdata_d = ld_data;
                end else begin
                    cnt_d = cnt - 1'b1;
                end
            end
            RESP:    state_d = IDLE;
            default: state_d = state;
        endcase
        // Acceptance only happens in IDLE or RESP, so it overrides the defaults above.
        if (accept) begin
            if (req_err || req_write) begin
                state_d      = RESP;
                resp_valid_d = 1'b1;
                resp_error_d = req_err;
                mem_we       = req_write && !req_err;
            end else if (LATENCY == 1) begin
                state_d      = RESP;
                resp_valid_d = 1'b1;
                resp_rdata_d = ld_data;
            end else begin
                state_d = WAIT;
                cnt_d   = CNT_W'(CNT_INIT);
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= IDLE;
            cnt        <= '0;
            resp_valid <= 1'b0;
            resp_error <= 1'b0;
            resp_rdata <= '0;
            ld_idx_q   <= '0;
            ld_off_q   <= '0;
            ld_sz_q    <= SZ_B;
            ld_uns_q   <= 1'b0;
        end else begin
            state      <= state_d;
            cnt        <= cnt_d;
            resp_valid <= resp_valid_d;
            resp_error <= resp_error_d;
            resp_rdata <= resp_rdata_d;
            if (accept) begin
                ld_idx_q <= req_idx;
                ld_off_q <= req_off;
                ld_sz_q  <= req_sz;
                ld_uns_q <= req_unsigned;
            end
        end
    end

    // Array contents survive reset.
    always_ff @(posedge clk) begin
        if (mem_we) mem[req_idx] <= st_merged;
    end

endmodule

// File: tb/tb_lsu_data_memory.sv
// Directed and randomized checks of lsu_data_memory against a byte-array
// reference model.
module tb_lsu_data_memory;
    import lsu_pkg::*;

    localparam int DEPTH   = 1024;
    localparam int LATENCY = 2;
    localparam int ADDR_W  = 64;

    logic              clk = 1'b0;
    logic              reset_n = 1'b0;
    logic              req_valid = 1'b0;
    logic              req_ready;
    logic              req_write = 1'b0;
    logic [1:0]        req_size = 2'd0;
    logic              req_unsigned = 1'b0;
    logic [ADDR_W-1:0] req_addr = '0;
    logic [63:0]       req_wdata = '0;
    logic              resp_valid;
    logic [63:0]       resp_rdata;
    logic              resp_error;
    logic              busy;
    lsu_state_e        fsm_state;

    int total = 0;
    int passed = 0;
    logic [7:0] ref_mem [DEPTH*8];

    always #5 clk = ~clk;

    lsu_data_memory #(.XLEN(64), .DEPTH(DEPTH), .ADDR_W(ADDR_W), .LATENCY(LATENCY)) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_write    (req_write),
        .req_size     (req_size),
        .req_unsigned (req_unsigned),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .resp_valid   (resp_valid),
        .resp_rdata   (resp_rdata),
        .resp_error   (resp_error),
        .busy         (busy),
        .fsm_state    (fsm_state)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) begin
            passed++;
        end else begin
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Byte-addressed reference: little-endian bytes, extension by hand.
    task automatic model(input logic w, input logic [1:0] sz, input logic uns,
                         input logic [63:0] addr, input logic [63:0] wd,
                         output logic [63:0] exp_d, output logic exp_e);
        int n;
        n = 1 << sz;
        exp_e = ((addr % 64'(n)) != 0) || (addr >= 64'(DEPTH * 8));
        exp_d = '0;
        if (!exp_e) begin
            if (w) begin
                for (int i = 0; i < n; i++) ref_mem[int'(addr) + i] = wd[8*i +: 8];
            end else begin
                for (int i = 0; i < n; i++) exp_d[8*i +: 8] = ref_mem[int'(addr) + i];
                if (!uns && n < 8 && exp_d[8*n-1])
                    for (int i = n; i < 8; i++) exp_d[8*i +: 8] = 8'hFF;
            end
        end
    endtask

    task automatic drive(input logic w, input logic [1:0] sz, input logic uns,
                         input logic [63:0] addr, input logic [63:0] wd);
        req_valid    = 1'b1;
        req_write    = w;
        req_size     = sz;
        req_unsigned = uns;
        req_addr     = addr;
        req_wdata    = wd;
    endtask

    task automatic xact(input string tag, input logic w, input logic [1:0] sz, input logic uns,
                        input logic [63:0] addr, input logic [63:0] wd, output logic [63:0] got);
        logic [63:0] exp_d;
        logic        exp_e;
        int          lat, cyc;
        model(w, sz, uns, addr, wd, exp_d, exp_e);
        lat = (w || exp_e) ? 1 : LATENCY;
        @(negedge clk);
        drive(w, sz, uns, addr, wd);
        cyc = 0;
        while (!req_ready && cyc < 20) begin
            @(negedge clk);
            cyc++;
        end
        chk({tag, " ready"}, 64'(req_ready), 64'd1);
        @(negedge clk);
        req_valid = 1'b0;
        cyc = 1;
        while (!resp_valid && cyc < 20) begin
            chk({tag, " quiet"}, resp_rdata | 64'(resp_error), 64'd0);
            @(negedge clk);
            cyc++;
        end
        chk({tag, " latency"}, 64'(cyc), 64'(lat));
        chk({tag, " valid"}, 64'(resp_valid), 64'd1);
        chk({tag, " rdata"}, resp_rdata, exp_d);
        chk({tag, " error"}, 64'(resp_error), 64'(exp_e));
        got = resp_rdata;
        @(negedge clk);
        chk({tag, " pulse"}, 64'(resp_valid), 64'd0);
    endtask

    initial begin
        logic [63:0] got, ea, eb;
        logic        ee;

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst ready", 64'(req_ready), 64'd1);
        chk("rst busy", 64'(busy), 64'd0);
        chk("rst valid", 64'(resp_valid), 64'd0);
        chk("rst rdata", resp_rdata, 64'd0);
        chk("rst state", 64'(fsm_state), 64'(IDLE));
        reset_n = 1'b1;

        // Initialise the low words so every later load has known contents
        for (int i = 0; i < 32; i++)
            xact("init", 1'b1, 2'd3, 1'b0, 64'(i * 8), {$urandom, $urandom}, got);

        // Store/load double
        xact("st d", 1'b1, 2'd3, 1'b0, 64'h10, 64'h1122334455667788, got);
        xact("ld d", 1'b0, 2'd3, 1'b0, 64'h10, 64'h0, got);
        chk("ld d const", got, 64'h1122334455667788);

        // Lane merge and extension
        xact("st b", 1'b1, 2'd0, 1'b0, 64'h13, 64'hAAAA_AAAA_AAAA_AA80, got);
        xact("ld bs", 1'b0, 2'd0, 1'b0, 64'h13, 64'h0, got);
        chk("ld bs const", got, 64'hFFFFFFFFFFFFFF80);
        xact("ld bu", 1'b0, 2'd0, 1'b1, 64'h13, 64'h0, got);
        chk("ld bu const", got, 64'h80);
        xact("ld merged", 1'b0, 2'd3, 1'b0, 64'h10, 64'h0, got);
        chk("ld merged const", got, 64'h1122334480667788);

        // Misaligned and out of range
        xact("mis ld h", 1'b0, 2'd1, 1'b0, 64'h21, 64'h0, got);
        xact("mis st w", 1'b1, 2'd2, 1'b0, 64'h22, 64'hDEADBEEF, got);
        xact("ld 20", 1'b0, 2'd3, 1'b0, 64'h20, 64'h0, got);
        xact("oor st", 1'b1, 2'd3, 1'b0, 64'h2000, 64'hCAFEF00DCAFEF00D, got);
        xact("ld 0", 1'b0, 2'd3, 1'b0, 64'h0, 64'h0, got);

        // Back-to-back: B is held through WAIT and taken in A's RESP cycle
        model(1'b0, 2'd3, 1'b0, 64'h10, 64'h0, ea, ee);
        model(1'b0, 2'd0, 1'b0, 64'h13, 64'h0, eb, ee);
        @(negedge clk);
        drive(1'b0, 2'd3, 1'b0, 64'h10, 64'h0);
        @(negedge clk);
        drive(1'b0, 2'd0, 1'b0, 64'h13, 64'h0);
        chk("b2b wait ready", 64'(req_ready), 64'd0);
        chk("b2b wait busy", 64'(busy), 64'd1);
        chk("b2b wait valid", 64'(resp_valid), 64'd0);
        @(negedge clk);
        chk("b2b a valid", 64'(resp_valid), 64'd1);
        chk("b2b a rdata", resp_rdata, ea);
        chk("b2b resp ready", 64'(req_ready), 64'd1);
        @(negedge clk);
        req_valid = 1'b0;
        chk("b2b gap valid", 64'(resp_valid), 64'd0);
        chk("b2b b waiting", 64'(fsm_state), 64'(WAIT));
        @(negedge clk);
        chk("b2b b valid", 64'(resp_valid), 64'd1);
        chk("b2b b rdata", resp_rdata, eb);
        @(negedge clk);
        chk("b2b b pulse", 64'(resp_valid), 64'd0);

        // Reset mid-load
        @(negedge clk);
        drive(1'b0, 2'd3, 1'b0, 64'h18, 64'h0);
        @(negedge clk);
        req_valid = 1'b0;
        chk("rml busy", 64'(busy), 64'd1);
        #1 reset_n = 1'b0;
        #1;
        chk("rml busy0", 64'(busy), 64'd0);
        chk("rml ready1", 64'(req_ready), 64'd1);
        chk("rml state", 64'(fsm_state), 64'(IDLE));
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("rml no pulse", 64'(resp_valid), 64'd0);
        end
        reset_n = 1'b1;
        @(negedge clk);
        chk("rml after", 64'(resp_valid), 64'd0);
        xact("rml ld 18", 1'b0, 2'd3, 1'b0, 64'h18, 64'h0, got);
        xact("rml ld 10", 1'b0, 2'd3, 1'b0, 64'h10, 64'h0, got);
        chk("rml survive", got, 64'h1122334480667788);

        // Randomized mix
        for (int i = 0; i < 200; i++) begin
            logic [63:0] a;
            a = 64'($urandom_range(0, 255));
            if ($urandom_range(0, 9) == 0) a = {$urandom, $urandom} | 64'h2000;
            xact("rand", 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
                 1'($urandom_range(0, 1)), a, {$urandom, $urandom}, got);
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/lsu_data_memory.md
Name: lsu_data_memory

Overview:
- Parametrised successor to the single-cycle data memory: a load/store data memory with a valid/ready request port and a registered response port.
- Supports byte, half, word and double accesses, with sign or zero extension on loads and byte-lane merging on stores.
- Read latency is configurable. Misaligned and out-of-range accesses are detected and flagged.
- Sits between the execute stage / LSU and the backing RAM array of the multi-cycle and pipelined cores.

Parameters:
- XLEN, 64, data width in bits; only 64 is supported.
- DEPTH, 1024, number of XLEN-bit words; must be a power of 2.
- ADDR_W, 64, request address width.
- LATENCY, 2, read latency in cycles from accept to response; must be at least 1.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  block can accept a request this cycle.
- req_write  in  1  1 = store, 0 = load.
- req_size  in  2  access size: 0 = byte, 1 = half, 2 = word, 3 = double (funct3[1:0]).
- req_unsigned  in  1  zero-extend the load (funct3[2]); ignored for size 3 and for stores.
- req_addr  in  ADDR_W  byte address.
- req_wdata  in  XLEN  store data; the low 8<<req_size bits are used.
- resp_valid  out  1  single-cycle response pulse.
- resp_rdata  out  XLEN  load result, extended per size and signedness; 0 for stores and errors.
- resp_error  out  1  qualifies resp_valid; 1 = misaligned or out of range.
- busy  out  1  an operation is outstanding (state is not IDLE).

Behaviour:
- Clock and reset: one clock, clk; reset_n is asynchronous, active-low.
- FSM states are IDLE, WAIT and RESP. Only one operation may be outstanding at a time.
- req_ready is 1 in IDLE and in RESP, and 0 in WAIT. A request is accepted when req_valid && req_ready at a rising edge; that cycle is cycle 0.
- Address fields:
  - byte offset = addr[2:0]
  - word index = addr[IDX+2:3], where IDX = log2(DEPTH)
  - out of range = any bit of addr[ADDR_W-1:IDX+3] set
  - misaligned = (size 1 and addr[0]) or (size 2 and addr[1:0] != 0) or (size 3 and addr[2:0] != 0)
- Error: either condition gives no array access. The response comes in cycle 1 with resp_error=1 and resp_rdata=0.
- Store:
  - Lanes offset .. offset+(1<<size)-1 of the word are merged with req_wdata, taken from its low bytes.
  - The write commits at the accepting edge.
  - The response comes in cycle 1 with resp_error=0 and resp_rdata=0.
- Load:
  - The word and lane are captured at accept.
  - Data is shifted right by offset*8, masked to the size, and then sign-extended (req_unsigned=0) or zero-extended.
  - The response comes in cycle LATENCY.
  - With LATENCY=1 the FSM goes IDLE->RESP. Otherwise it goes IDLE->WAIT, a down-counter is loaded with LATENCY-2, and WAIT->RESP happens when the counter reaches 0.
  - The array is read on the edge entering RESP; this yields read-after-write coherence.
- Transitions:
  - RESP -> IDLE, unless a new request is accepted in the RESP cycle; that request starts as cycle 0 (back-to-back).
  - Stores and errors go IDLE/RESP -> RESP directly.
- Output discipline:
  - resp_valid is high for exactly one cycle per accepted request.
  - resp_rdata and resp_error are held at 0 whenever resp_valid=0.
- Reset, asserted at any time, including mid-operation:
  - state goes to IDLE, the counter to 0, and resp_valid, resp_rdata and resp_error to 0.
  - req_ready=1 and busy=0 immediately; any pending load is abandoned.
  - Array contents are not reset. A store already committed stays committed.
- Requests while req_ready=0 are ignored. The requester must hold them until accepted.

Decomposition:
- Shared package lsu_pkg:
  - size enum SZ_B=0, SZ_H=1, SZ_W=2, SZ_D=3
  - state enum IDLE/WAIT/RESP
  - function size_bytes(size)
  - function load_extend(word, offset, size, unsigned)
- One sub-module, lsu_lane_align:
  - combinational store byte-enable and data-merge generation
  - load extract and extend logic
  - reused later by the cache.

Test Plan:
- Store/load double: store addr 0x10, size 3, data 0x1122334455667788 -> resp_valid in cycle 1 with error 0. Then load addr 0x10, size 3 -> resp_rdata 0x1122334455667788 in cycle LATENCY (2).
- Lane merge and sign extension:
  - store byte 0x80 at 0x13
  - load byte signed at 0x13 -> 0xFFFFFFFFFFFFFF80
  - load byte unsigned at 0x13 -> 0x80
  - load double at 0x10 -> 0x1122334480667788
- Misaligned: load half at 0x21 -> cycle 1 resp_error=1, resp_rdata=0. A store word to 0x22 -> error, and the word at 0x20 is unchanged.
- Out of range: store double at 0x2000 (DEPTH=1024) -> error, and the word at index 0 is unchanged.
- Back-to-back: a new load presented during the RESP cycle of the previous load is accepted that cycle, with responses LATENCY cycles apart. req_ready=0 during WAIT; a request held there is not accepted until RESP.
- Reset mid-load: drop reset_n in WAIT -> resp_valid never pulses, busy=0 and req_ready=1 immediately, and earlier stored data survives.
